// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared fetch-stage types and constants
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_ISSUE = 2'd0,
      ST_WAIT  = 2'd1,
      ST_HOLD  = 2'd2
   } fetch_state_t;

   localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;
   localparam logic [31:0] WORD_ALIGN_MASK   = 32'hFFFF_FFFC;

endpackage

// File: rtl/next_pc_sel.sv
// rtl/next_pc_sel.sv - redirect detect and target select, branch beats jump
module next_pc_sel
   import pipe_pkg::*;
(
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   output logic        redirect,
   output logic [31:0] target
);

   logic [31:0] w_raw_target;

   assign redirect     = br_taken | jump;
   assign w_raw_target = br_taken ? br_target : jump_target;
   assign target       = w_raw_target & WORD_ALIGN_MASK;

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC register, fetch FSM and IF/ID pipeline register
module pc_fetch_unit
   import pipe_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
   parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic        ifid_valid,
   output logic [31:0] ifid_instr,
   output logic [31:0] ifid_pc_plus_4,
   output logic [31:0] pc
);

   fetch_state_t r_state;
   logic [31:0]  r_pc;
   logic [31:0]  r_fetch_addr;
   logic [31:0]  r_hold_instr;
   logic         r_kill;
   logic         r_ifid_valid;
   logic [31:0]  r_ifid_instr;
   logic [31:0]  r_ifid_pc_plus_4;

   logic         w_redirect;
   logic [31:0]  w_target;
   logic [31:0]  w_pc_plus_4;
   logic [31:0]  w_fetch_plus_4;

   next_pc_sel u_next_pc_sel (
      .br_taken    (br_taken),
      .br_target   (br_target),
      .jump        (jump),
      .jump_target (jump_target),
      .redirect    (w_redirect),
      .target      (w_target)
   );

   assign w_pc_plus_4    = r_pc + 32'd4;
   assign w_fetch_plus_4 = r_fetch_addr + 32'd4;

   // Address comes from fetch_addr once a request is outstanding so it stays stable.
   assign imem_req  = (r_state == ST_ISSUE) ? (!stall && !w_redirect) : (r_state == ST_WAIT);
   assign imem_addr = (r_state == ST_ISSUE) ? r_pc : r_fetch_addr;

   assign ifid_valid     = r_ifid_valid;
   assign ifid_instr     = r_ifid_instr;
   assign ifid_pc_plus_4 = r_ifid_pc_plus_4;
   assign pc             = r_pc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state          <= ST_ISSUE;
         r_pc             <= RESET_PC;
         r_fetch_addr     <= 32'd0;
         r_hold_instr     <= 32'd0;
         r_kill           <= 1'b0;
         r_ifid_valid     <= 1'b0;
         r_ifid_instr     <= NOP_INSTR;
         r_ifid_pc_plus_4 <= 32'd0;
      end else if (w_redirect) begin
         r_pc         <= w_target;
         r_ifid_valid <= 1'b0;
         r_ifid_instr <= NOP_INSTR;
         // An in-flight response must still drain before the new target is fetched.
         if (r_state == ST_WAIT && !imem_ready) begin
            r_kill <= 1'b1;
         end else begin
            r_kill  <= 1'b0;
            r_state <= ST_ISSUE;
         end
      end else begin
         case (r_state)
            ST_ISSUE: begin
               if (!stall) begin
                  r_fetch_addr <= r_pc;
                  if (imem_ready) begin
                     r_ifid_valid     <= 1'b1;
                     r_ifid_instr     <= imem_rdata;
                     r_ifid_pc_plus_4 <= w_pc_plus_4;
                     r_pc             <= w_pc_plus_4;
                  end else begin
                     r_state      <= ST_WAIT;
                     r_ifid_valid <= 1'b0;
                     r_ifid_instr <= NOP_INSTR;
                  end
               end
            end
            ST_WAIT: begin
               if (imem_ready && r_kill) begin
                  r_kill  <= 1'b0;
                  r_state <= ST_ISSUE;
                  if (!stall) begin
                     r_ifid_valid <= 1'b0;
                     r_ifid_instr <= NOP_INSTR;
                  end
               end else if (imem_ready && !stall) begin
                  r_state          <= ST_ISSUE;
                  r_ifid_valid     <= 1'b1;
                  r_ifid_instr     <= imem_rdata;
                  r_ifid_pc_plus_4 <= w_fetch_plus_4;
                  r_pc             <= w_fetch_plus_4;
               end else if (imem_ready) begin
                  r_hold_instr <= imem_rdata;
                  r_state      <= ST_HOLD;
               end else if (!stall) begin
                  r_ifid_valid <= 1'b0;
                  r_ifid_instr <= NOP_INSTR;
               end
            end
            ST_HOLD: begin
               if (!stall) begin
                  r_state          <= ST_ISSUE;
                  r_ifid_valid     <= 1'b1;
                  r_ifid_instr     <= r_hold_instr;
                  r_ifid_pc_plus_4 <= w_fetch_plus_4;
                  r_pc             <= w_fetch_plus_4;
               end
            end
            default: r_state <= ST_ISSUE;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        br_taken = 1'b0;
   logic [31:0] br_target = 32'd0;
   logic        jump = 1'b0;
   logic [31:0] jump_target = 32'd0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        ifid_valid;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc_plus_4;
   logic [31:0] pc;

   int checks = 0;
   int failures = 0;
   int mem_wait = 0;
   int wait_cnt = 0;

   localparam logic [31:0] XORV = 32'hA5A5_0000;

   pc_fetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .br_taken       (br_taken),
      .br_target      (br_target),
      .jump           (jump),
      .jump_target    (jump_target),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ready     (imem_ready),
      .imem_rdata     (imem_rdata),
      .ifid_valid     (ifid_valid),
      .ifid_instr     (ifid_instr),
      .ifid_pc_plus_4 (ifid_pc_plus_4),
      .pc             (pc)
   );

   always #5 clk = ~clk;

   // Memory answers after mem_wait cycles of a held request.
   assign imem_ready = imem_req && (wait_cnt >= mem_wait);
   assign imem_rdata = imem_addr ^ XORV;

   always @(posedge clk or posedge rst) begin
      if (rst) wait_cnt <= 0;
      else if (imem_req && imem_ready) wait_cnt <= 0;
      else if (imem_req) wait_cnt <= wait_cnt + 1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      checks++; if (pc !== 32'd0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'd0); end
      checks++; if (ifid_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", ifid_valid); end
      checks++; if (ifid_instr !== 32'd0) begin failures++; $display("FAIL reset_instr got=%h exp=%h", ifid_instr, 32'd0); end
      checks++; if (ifid_pc_plus_4 !== 32'd0) begin failures++; $display("FAIL reset_pp4 got=%h exp=%h", ifid_pc_plus_4, 32'd0); end
      rst = 1'b0;
   endtask

   task automatic test_zero_wait();
      logic [31:0] exp_pp4;
      mem_wait = 0;
      for (int k = 1; k <= 4; k++) begin
         step();
         exp_pp4 = 32'(4 * k);
         checks++; if (ifid_valid !== 1'b1) begin failures++; $display("FAIL zw_valid%0d got=%b exp=1", k, ifid_valid); end
         checks++; if (ifid_pc_plus_4 !== exp_pp4) begin failures++; $display("FAIL zw_pp4_%0d got=%h exp=%h", k, ifid_pc_plus_4, exp_pp4); end
         checks++; if (ifid_instr !== ((exp_pp4 - 32'd4) ^ XORV)) begin failures++; $display("FAIL zw_instr%0d got=%h exp=%h", k, ifid_instr, (exp_pp4 - 32'd4) ^ XORV); end
      end
   endtask

   task automatic test_multi_wait();
      mem_wait = 2;
      do_reset();
      step();
      step();
      step();
      checks++; if (ifid_pc_plus_4 !== 32'h4 || ifid_valid !== 1'b1) begin failures++; $display("FAIL mw_first got=%h/%b exp=4/1", ifid_pc_plus_4, ifid_valid); end
      for (int c = 0; c < 3; c++) begin
         checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin failures++; $display("FAIL mw_addr%0d got=%b/%h exp=1/4", c, imem_req, imem_addr); end
         step();
         if (c < 2) begin
            checks++; if (pc !== 32'h4 || ifid_valid !== 1'b0) begin failures++; $display("FAIL mw_pc%0d got=%h/%b exp=4/0", c, pc, ifid_valid); end
         end
      end
      checks++; if (pc !== 32'h8) begin failures++; $display("FAIL mw_pc_step got=%h exp=8", pc); end
      checks++; if (ifid_pc_plus_4 !== 32'h8 || ifid_instr !== (32'h4 ^ XORV)) begin failures++; $display("FAIL mw_cap got=%h/%h exp=8/%h", ifid_pc_plus_4, ifid_instr, 32'h4 ^ XORV); end
   endtask

   task automatic test_redirect_kill();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin failures++; $display("FAIL rk_issue got=%b/%h exp=1/8", imem_req, imem_addr); end
      step();
      br_taken = 1'b1;
      br_target = 32'h100;
      step();
      br_taken = 1'b0;
      checks++; if (pc !== 32'h100 || ifid_valid !== 1'b0) begin failures++; $display("FAIL rk_redirect got=%h/%b exp=100/0", pc, ifid_valid); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin failures++; $display("FAIL rk_drain got=%b/%h exp=1/8", imem_req, imem_addr); end
      step();
      checks++; if (pc !== 32'h100 || ifid_valid !== 1'b0) begin failures++; $display("FAIL rk_discard got=%h/%b exp=100/0", pc, ifid_valid); end
      checks++; if (imem_addr !== 32'h100) begin failures++; $display("FAIL rk_newaddr got=%h exp=100", imem_addr); end
      step();
      step();
      step();
      checks++; if (ifid_valid !== 1'b1 || ifid_pc_plus_4 !== 32'h104 || ifid_instr !== (32'h100 ^ XORV)) begin failures++; $display("FAIL rk_cap got=%b/%h/%h exp=1/104/%h", ifid_valid, ifid_pc_plus_4, ifid_instr, 32'h100 ^ XORV); end
   endtask

   task automatic test_priority();
      mem_wait = 0;
      jump = 1'b1;
      jump_target = 32'h301;
      step();
      checks++; if (pc !== 32'h300) begin failures++; $display("FAIL pr_jump got=%h exp=300", pc); end
      br_taken = 1'b1;
      br_target = 32'h200;
      jump_target = 32'h300;
      #1;
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL pr_noreq got=%b exp=0", imem_req); end
      step();
      checks++; if (pc !== 32'h200 || ifid_valid !== 1'b0) begin failures++; $display("FAIL pr_both got=%h/%b exp=200/0", pc, ifid_valid); end
      jump = 1'b0;
      br_target = 32'h203;
      step();
      checks++; if (pc !== 32'h200) begin failures++; $display("FAIL pr_align got=%h exp=200", pc); end
      br_taken = 1'b0;
      step();
      checks++; if (ifid_valid !== 1'b1 || ifid_pc_plus_4 !== 32'h204 || ifid_instr !== (32'h200 ^ XORV)) begin failures++; $display("FAIL pr_cap got=%b/%h/%h exp=1/204/%h", ifid_valid, ifid_pc_plus_4, ifid_instr, 32'h200 ^ XORV); end
   endtask

   task automatic test_stall_hold();
      mem_wait = 1;
      stall = 1'b1;
      #1;
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL st_noreq got=%b exp=0", imem_req); end
      step();
      checks++; if (pc !== 32'h204 || ifid_valid !== 1'b1 || ifid_pc_plus_4 !== 32'h204) begin failures++; $display("FAIL st_hold got=%h/%b/%h exp=204/1/204", pc, ifid_valid, ifid_pc_plus_4); end
      stall = 1'b0;
      step();
      stall = 1'b1;
      #1;
      checks++; if (imem_req !== 1'b1 || imem_ready !== 1'b1 || imem_addr !== 32'h204) begin failures++; $display("FAIL st_resp got=%b/%b/%h exp=1/1/204", imem_req, imem_ready, imem_addr); end
      for (int c = 0; c < 2; c++) begin
         step();
         checks++; if (imem_req !== 1'b0 || pc !== 32'h204 || ifid_valid !== 1'b0 || ifid_pc_plus_4 !== 32'h204) begin failures++; $display("FAIL st_held%0d got=%b/%h/%b/%h exp=0/204/0/204", c, imem_req, pc, ifid_valid, ifid_pc_plus_4); end
      end
      stall = 1'b0;
      step();
      checks++; if (ifid_valid !== 1'b1 || ifid_pc_plus_4 !== 32'h208 || ifid_instr !== (32'h204 ^ XORV) || pc !== 32'h208) begin failures++; $display("FAIL st_cap got=%b/%h/%h/%h exp=1/208/%h/208", ifid_valid, ifid_pc_plus_4, ifid_instr, pc, 32'h204 ^ XORV); end
   endtask

   task automatic test_reset_mid_wait();
      mem_wait = 3;
      step();
      rst = 1'b1;
      #1;
      checks++; if (pc !== 32'd0 || ifid_valid !== 1'b0 || imem_addr !== 32'd0) begin failures++; $display("FAIL rmw_async got=%h/%b/%h exp=0/0/0", pc, ifid_valid, imem_addr); end
      step();
      rst = 1'b0;
      mem_wait = 0;
      step();
      checks++; if (ifid_valid !== 1'b1 || ifid_pc_plus_4 !== 32'h4 || ifid_instr !== XORV) begin failures++; $display("FAIL rmw_restart got=%b/%h/%h exp=1/4/%h", ifid_valid, ifid_pc_plus_4, ifid_instr, XORV); end
   endtask

   task automatic test_wrap();
      jump = 1'b1;
      jump_target = 32'hFFFF_FFFC;
      step();
      jump = 1'b0;
      checks++; if (pc !== 32'hFFFF_FFFC || imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wr_pc got=%h/%h exp=fffffffc", pc, imem_addr); end
      step();
      checks++; if (pc !== 32'd0 || ifid_pc_plus_4 !== 32'd0 || ifid_valid !== 1'b1 || ifid_instr !== 32'h5A5A_FFFC) begin failures++; $display("FAIL wr_cap got=%h/%h/%b/%h exp=0/0/1/5a5afffc", pc, ifid_pc_plus_4, ifid_valid, ifid_instr); end
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_multi_wait();
      test_redirect_kill();
      test_priority();
      test_stall_hold();
      test_reset_mid_wait();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Instruction-fetch stage that owns the program counter. It consumes the branch and jump redirects resolved downstream and issues fetches to instruction memory over a req/ready handshake. Fetched instructions go into the IF/ID pipeline register. It handles multi-cycle memory latency, hazard stalls, and flushing of wrong-path fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0
NOP_INSTR, 32'h0000_0000, instruction word inserted into IF/ID on bubble or flush

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
stall  in  1  hazard-unit request to hold IF/ID and the PC
br_taken  in  1  branch resolved taken (PCSrc)
br_target  in  32  branch target address
jump  in  1  jump request
jump_target  in  32  absolute jump target
imem_req  out  1  fetch request
imem_addr  out  32  fetch address, word aligned
imem_ready  in  1  memory returns imem_rdata this cycle
imem_rdata  in  32  instruction word
ifid_valid  out  1  IF/ID holds a real instruction
ifid_instr  out  32  IF/ID instruction
ifid_pc_plus_4  out  32  address of fetched instruction + 4
pc  out  32  current next-fetch PC (debug)

Behaviour:
- Interface: one clock (clk); rst is asynchronous and active-high.
- Reset values: pc=RESET_PC, fetch_addr=0, state=ISSUE, kill=0, ifid_valid=0, ifid_instr=NOP_INSTR, ifid_pc_plus_4=0, hold_instr=0.
- Redirect: redirect = br_taken | jump.
  - target = br_taken ? br_target : jump_target. Branch beats jump.
  - target[1:0] is forced to 0.
- Arithmetic: all address arithmetic is 32-bit modulo. 32'hFFFF_FFFC + 4 = 0.
- imem_addr is pc in ISSUE and fetch_addr in WAIT/HOLD. The address stays stable while a request is outstanding.
- State ISSUE:
  - imem_req = !stall & !redirect.
  - On issue, fetch_addr <= pc.
  - If imem_ready is also asserted (0-wait memory): capture the response this cycle; stay in ISSUE.
  - If imem_ready is not asserted: go to WAIT.
- State WAIT:
  - imem_req=1.
  - On imem_ready with kill=1: discard the data, kill<=0, go to ISSUE.
  - On imem_ready with kill=0 and stall=0: capture the response, go to ISSUE.
  - On imem_ready with kill=0 and stall=1: hold_instr <= imem_rdata, go to HOLD.
- State HOLD:
  - imem_req=0.
  - When stall=0: capture from hold_instr, go to ISSUE.
- Capture means:
  - ifid_valid<=1, ifid_instr<=data, ifid_pc_plus_4<=fetch_addr+4 (or pc+4 for a 0-wait capture in ISSUE).
  - pc <= that same +4 value.
- IF/ID update:
  - No capture, stall=0: ifid_valid<=0, ifid_instr<=NOP_INSTR (bubble).
  - stall=1 with no redirect: IF/ID and pc hold.
- Redirect (overrides stall):
  - pc<=target; IF/ID flushed (ifid_valid<=0, ifid_instr<=NOP_INSTR).
  - ISSUE: no request issued this cycle.
  - WAIT without imem_ready: kill<=1, stay in WAIT until the old response drains.
  - WAIT with imem_ready: data discarded, go to ISSUE.
  - HOLD: hold_instr discarded, go to ISSUE.
  - Redirect while kill=1: pc is updated again and kill stays 1.
  - A response is never captured in the same cycle as a redirect.
- Latency: with a 0-wait memory and no stalls, one instruction per cycle. The first fetch after reset is issued in the first cycle after rst deasserts. The first redirect-target instruction reaches IF/ID 2 cycles after the redirect cycle.
- Reset mid-transaction: state returns to ISSUE and the outstanding response is ignored. Memory is required to abort on rst.

Decomposition:
- Shared package pipe_pkg:
  - fetch state encoding (ISSUE=2'd0, WAIT=2'd1, HOLD=2'd2)
  - NOP_INSTR and RESET_PC defaults
  - word-align mask 32'hFFFF_FFFC
- One sub-module, next_pc_sel: combinational redirect priority and target select. It is the same select the downstream next-PC path uses, so both ends agree on branch-over-jump priority.
- The FSM, PC register and IF/ID register stay in pc_fetch_unit.

Test Plan:
- 0-wait memory, imem_rdata = addr ^ 32'hA5A5_0000, no stall, 4 cycles after reset → IF/ID pc_plus_4 = 4, 8, 12, 16 consecutively, ifid_valid=1 every cycle.
- 2-wait memory → imem_addr stable at 0x4 for 3 cycles with imem_req=1; one capture per 3 cycles; pc steps 4→8 only at capture.
- Redirect with kill: br_taken=1, br_target=0x100 in WAIT with the fetch of 0x8 outstanding → kill=1; the 0x8 response is discarded; next imem_addr=0x100; IF/ID receives pc_plus_4=0x104.
- Branch and jump together: br_taken=1 (0x200), jump=1 (0x300) → pc=0x200. Misaligned target 0x203 → pc=0x200.
- Stall during response: stall=1 while ready arrives → HOLD, IF/ID unchanged, imem_req=0. stall falls → captured next cycle with the correct pc_plus_4.
- Corner cases:
  - rst asserted mid-WAIT → immediate pc=RESET_PC, ifid_valid=0.
  - pc=0xFFFF_FFFC fetch → pc wraps to 0, ifid_pc_plus_4=0.
